// File: rtl/prog_mem_pkg.sv
// Shared constants for the RV32i program-memory fetch path.
// Fault codes, build defaults and the byte-offset helper.
package prog_mem_pkg;

  localparam int ADDR_WIDTH_DEF   = 12;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int MEM_DEPTH_DEF    = 1024;
  localparam int READ_LATENCY_DEF = 1;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  function automatic int offset_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  localparam int OFFSET_BITS = offset_bits(DATA_WIDTH_DEF);

endpackage

// File: rtl/prog_mem_pipe_if.sv
// Fetch request/response, flush and boot-loader load port of prog_mem_pipe.
// master = fetch stage / boot loader side, slave = memory side.
interface prog_mem_pipe_if #(
  parameter int ADDR_WIDTH = prog_mem_pkg::ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = prog_mem_pkg::DATA_WIDTH_DEF
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic [1:0]              rsp_fault;
  logic                    flush;
  logic                    ld_en;
  logic [ADDR_WIDTH-1:0]   ld_addr;
  logic [DATA_WIDTH-1:0]   ld_data;
  logic [DATA_WIDTH/8-1:0] ld_be;

  modport master (
    output req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data, ld_be,
    input  req_ready, rsp_valid, rsp_data, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data, ld_be,
    output req_ready, rsp_valid, rsp_data, rsp_fault
  );
endinterface

// File: rtl/prog_mem_rsp_fifo.sv
// Circular response buffer plus the occupancy counter that throttles requests.
// occ counts in-flight and buffered responses; cnt counts only stored entries.
module prog_mem_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             occ_inc_i,
  input  logic             occ_dec_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, occ_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Storage, pointers and counters; a flush keeps only a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= occ_inc_i ? CW'(1) : '0;
    end else begin
      if (push_i) begin
        buf_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      case ({occ_inc_i, occ_dec_i})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_o  = buf_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (occ_q >= DEPTH_C);
endmodule

// File: rtl/prog_mem_pipe.sv
// Instruction memory with request/response handshake, READ_LATENCY read pipeline,
// back-pressure buffer, byte-enabled load port, fault reporting and flush.
module prog_mem_pipe
  import prog_mem_pkg::*;
#(
  parameter int    ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int    DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int    MEM_DEPTH    = MEM_DEPTH_DEF,
  parameter int    READ_LATENCY = READ_LATENCY_DEF,
  parameter string INIT_FILE    = ""
) (
  input logic            clk,
  input logic            rst_n,
  prog_mem_pipe_if.slave bus
);
  localparam int OFFS      = offset_bits(DATA_WIDTH);
  localparam int BE_W      = DATA_WIDTH / 8;
  localparam int IDX_W     = ADDR_WIDTH - OFFS;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);
  localparam int BUF_DEPTH = READ_LATENCY + 1;
  localparam int ENT_W     = DATA_WIDTH + 2;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
  logic [IDX_W-1:0]        req_idx_s, ld_idx_s;
  logic [1:0]              req_fault_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;
  logic                    accept_s, full_s, fifo_empty_s, push_s, pop_s, fire_s;
  logic                    rsp_valid_s, tail_v_s, unused_s;
  logic [ENT_W-1:0]        head_s, tail_e_s, rsp_ent_s;
  logic [READ_LATENCY-1:0] v_q;
  logic [ENT_W-1:0]        e_q [READ_LATENCY];

  assign req_idx_s = bus.req_addr[ADDR_WIDTH-1:OFFS];
  assign ld_idx_s  = bus.ld_addr[ADDR_WIDTH-1:OFFS];
  assign unused_s  = ^bus.ld_addr[OFFS-1:0];

  // Fault decode; the array is only indexed for in-range aligned fetches.
  always_comb begin
    req_fault_s = FAULT_OK;
    rd_word_s   = '0;
    if (|bus.req_addr[OFFS-1:0]) begin
      req_fault_s = FAULT_MISALIGN;
    end else if ({1'b0, req_idx_s} >= DEPTH_L) begin
      req_fault_s = FAULT_RANGE;
    end else begin
      req_fault_s = FAULT_OK;
      rd_word_s   = mem_q[req_idx_s[MEM_AW-1:0]];
    end
  end

  assign accept_s      = bus.req_valid && !full_s;
  assign bus.req_ready = !full_s;

  // Read pipeline; stage 0 samples the array before this edge's load write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) e_q[i] <= '0;
    end else begin
      v_q[0] <= accept_s;
      e_q[0] <= accept_s ? {req_fault_s, rd_word_s} : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        v_q[i] <= bus.flush ? 1'b0 : v_q[i-1];
        e_q[i] <= bus.flush ? '0 : e_q[i-1];
      end
    end
  end

  // Byte-enabled boot-loader writes; out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    if (bus.ld_en && ({1'b0, ld_idx_s} < DEPTH_L)) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.ld_be[b]) mem_q[ld_idx_s[MEM_AW-1:0]][b*8 +: 8] <= bus.ld_data[b*8 +: 8];
      end
    end
  end

  assign tail_v_s = v_q[READ_LATENCY-1];
  assign tail_e_s = e_q[READ_LATENCY-1];

  // An empty buffer is bypassed so the last stage is visible the cycle it arrives.
  assign rsp_valid_s   = !fifo_empty_s || tail_v_s;
  assign rsp_ent_s     = fifo_empty_s ? tail_e_s : head_s;
  assign fire_s        = rsp_valid_s && bus.rsp_ready;
  assign push_s        = tail_v_s && !(fifo_empty_s && bus.rsp_ready) && !bus.flush;
  assign pop_s         = !fifo_empty_s && bus.rsp_ready;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_fault = rsp_ent_s[ENT_W-1 -: 2];
  assign bus.rsp_data  = rsp_ent_s[DATA_WIDTH-1:0];

  prog_mem_rsp_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENT_W)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (bus.flush),
    .push_i      (push_s),
    .push_data_i (tail_e_s),
    .pop_i       (pop_s),
    .occ_inc_i   (accept_s),
    .occ_dec_i   (fire_s),
    .head_o      (head_s),
    .empty_o     (fifo_empty_s),
    .full_o      (full_s)
  );
endmodule

// File: tb/tb_prog_mem_pipe.sv
// Directed bench for prog_mem_pipe (READ_LATENCY=3, ADDR_WIDTH=13) with a
// timing-aware scoreboard and a reference copy of the array contents.
module tb_prog_mem_pipe;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int MD = 1024;
  localparam int RL = 3;
  localparam int BD = RL + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    fault;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_rsp = 0;
  exp_t sb[$];
  logic [DW-1:0] mdl [MD];

  prog_mem_pipe_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  prog_mem_pipe #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .MEM_DEPTH    (MD),
    .READ_LATENCY (RL),
    .INIT_FILE    ("")
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t exp_of(input logic [AW-1:0] a);
    exp_t e;
    e.due  = cyc + RL;
    e.data = '0;
    if (a[1:0] != 2'b00) begin
      e.fault = 2'b01;
    end else if (int'(a >> 2) >= MD) begin
      e.fault = 2'b10;
    end else begin
      e.fault = 2'b00;
      e.data  = mdl[int'(a >> 2)];
    end
    return e;
  endfunction

  // One clock: check outputs at negedge, update the model, advance past posedge.
  task automatic step(output bit acc);
    bit exp_v, fire;
    @(negedge clk);
    chk("req_ready", 64'(bus.req_ready), 64'(sb.size() < BD));
    exp_v = (sb.size() > 0) && (sb[0].due <= cyc);
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
    if (exp_v) begin
      chk("rsp_data", 64'(bus.rsp_data), 64'(sb[0].data));
      chk("rsp_fault", 64'(bus.rsp_fault), 64'(sb[0].fault));
    end
    fire = exp_v && bus.rsp_ready;
    acc  = bus.req_valid && (sb.size() < BD);
    if (fire) begin
      void'(sb.pop_front());
      n_rsp++;
    end
    if (bus.flush) sb.delete();
    if (acc) sb.push_back(exp_of(bus.req_addr));
    if (bus.ld_en && int'(bus.ld_addr >> 2) < MD) begin
      for (int b = 0; b < DW/8; b++) begin
        if (bus.ld_be[b]) mdl[int'(bus.ld_addr >> 2)][b*8 +: 8] = bus.ld_data[b*8 +: 8];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [AW-1:0] a);
    bit x;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    step(x);
    bus.req_valid = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    bit x;
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    bus.ld_be   = be;
    step(x);
    bus.ld_en   = 1'b0;
  endtask

  task automatic drain();
    bit x;
    for (int i = 0; i < 40 && sb.size() > 0; i++) step(x);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    step(x);
    step(x);
  endtask

  initial begin
    bit a;
    int k, n_acc;
    logic [AW-1:0] addrs [4];
    addrs = '{13'h000, 13'h004, 13'h010, 13'h020};
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.ld_en     = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.ld_be     = '0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_rsp_fault", 64'(bus.rsp_fault), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);

    load(13'h000, 32'h00500093, 4'hF);
    load(13'h004, 32'h00100113, 4'hF);
    load(13'h010, 32'h11223344, 4'hF);
    load(13'h020, 32'hCAFEF00D, 4'hF);

    // Back-to-back fetches with the consumer always ready
    bus.rsp_ready = 1'b1;
    n_rsp = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 13'h000;
    step(a);
    bus.req_addr  = 13'h004;
    step(a);
    bus.req_valid = 1'b0;
    drain();
    chk("t1_rsp_count", 64'(n_rsp), 64'd2);

    // Back-pressure: exactly BD accepted, then in-order drain
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    k = 0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.req_addr = addrs[k];
      step(a);
      if (a) begin
        n_acc++;
        if (k < 3) k++;
      end
    end
    chk("t2_accepted", 64'(n_acc), 64'(BD));
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    n_rsp = 0;
    drain();
    chk("t2_drained", 64'(n_rsp), 64'(BD));

    // Out-of-range load dropped; fault codes and precedence
    load(13'h1000, 32'hBADBAD00, 4'hF);
    bus.req_valid = 1'b1;
    bus.req_addr = 13'h002;  step(a);
    bus.req_addr = 13'h1000; step(a);
    bus.req_addr = 13'h0FFE; step(a);
    bus.req_addr = 13'h1002; step(a);
    bus.req_addr = 13'h000;  step(a);
    bus.req_valid = 1'b0;
    drain();

    // Read-before-write collision, then the merged word
    bus.ld_en     = 1'b1;
    bus.ld_addr   = 13'h010;
    bus.ld_data   = 32'hDEADBEEF;
    bus.ld_be     = 4'b0011;
    bus.req_valid = 1'b1;
    bus.req_addr  = 13'h010;
    step(a);
    bus.ld_en = 1'b0;
    step(a);
    bus.req_valid = 1'b0;
    drain();

    // Flush with a same-cycle request
    bus.req_valid = 1'b1;
    bus.req_addr = 13'h000; step(a);
    bus.req_addr = 13'h004; step(a);
    bus.req_addr = 13'h010; step(a);
    bus.flush    = 1'b1;
    bus.req_addr = 13'h020;
    step(a);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    n_rsp = 0;
    drain();
    chk("t5_one_rsp", 64'(n_rsp), 64'd1);

    // Asynchronous reset mid-stream; array contents survive
    bus.rsp_ready = 1'b0;
    req(13'h000);
    req(13'h004);
    for (int i = 0; i < 4; i++) step(a);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t6_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("t6_rsp_fault", 64'(bus.rsp_fault), 64'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_req_ready", 64'(bus.req_ready), 64'd1);
    bus.rsp_ready = 1'b1;
    n_rsp = 0;
    req(13'h010);
    drain();
    chk("t6_rsp_count", 64'(n_rsp), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
